// File: rtl/src_pkg.sv
// Shared constants and helpers for the src_pipe register pipeline.
package src_pkg;

    localparam int SRC_RST_VAL = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Width of a counter able to hold 0..depth inclusive, never narrower than one bit.
    function automatic int occWidth(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

endpackage

// File: rtl/src_pipe_stage.sv
// One pipeline stage: a valid bit plus data register that loads, holds or clears.
module src_pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             upValid_i,
    input  logic [WIDTH-1:0] upData_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Data only moves when a real item arrives, so a bubble never overwrites held data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = RST_VAL;
        end else if (load_i) begin
            valid_d = upValid_i;
            if (upValid_i) begin
                data_d = upData_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/src_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing and synchronous flush.
// Define SRC_PIPE_OCC_EN to add the registered occupancy output.
module src_pipe
    import src_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(SRC_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef SRC_PIPE_OCC_EN
    ,
    output logic [occWidth(DEPTH)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] stageValid;
    logic [DEPTH-1:0] stageReady;
    logic [WIDTH-1:0] stageData [DEPTH];

    // A stage may advance if any stage at or after it is empty, or the output drains.
    always_comb begin : readyChain
        logic suffixFull;
        suffixFull = 1'b1;
        stageReady = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            suffixFull    = suffixFull & stageValid[i];
            stageReady[i] = out_ready | ~suffixFull;
        end
    end

    assign in_ready  = stageReady[0] & ~flush & rst_n;
    assign out_valid = stageValid[DEPTH-1];
    assign out_data  = stageData[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : gStage
        logic             upValid;
        logic [WIDTH-1:0] upData;

        if (i == 0) begin : gHead
            assign upValid = in_valid & ~flush;
            assign upData  = in_data;
        end else begin : gBody
            assign upValid = stageValid[i-1];
            assign upData  = stageData[i-1];
        end

        src_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) uStage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (flush),
            .load_i    (stageReady[i]),
            .upValid_i (upValid),
            .upData_i  (upData),
            .valid_o   (stageValid[i]),
            .data_o    (stageData[i])
        );
    end

`ifdef SRC_PIPE_OCC_EN
    localparam int OCC_W = occWidth(DEPTH);

    logic             inXfer, outXfer;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign inXfer  = in_valid & in_ready;
    assign outXfer = out_valid & out_ready;

    // Simultaneous push and pop cancel out, so a full pipe streaming through stays at DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (inXfer && !outXfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!inXfer && outXfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_src_pipe.sv
// Directed and random checks of src_pipe at DEPTH 2, 3 and 4; occupancy checks follow SRC_PIPE_OCC_EN.
module tb_src_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    // Instance A: WIDTH 8, DEPTH 2
    logic       aFlush = 1'b0, aInValid = 1'b0, aOutReady = 1'b0;
    logic [7:0] aInData = '0;
    logic       aInReady, aOutValid;
    logic [7:0] aOutData;

    // Instance B: WIDTH 8, DEPTH 3
    logic       bFlush = 1'b0, bInValid = 1'b0, bOutReady = 1'b1;
    logic [7:0] bInData = '0;
    logic       bInReady, bOutValid;
    logic [7:0] bOutData;

    // Instance C: WIDTH 16, DEPTH 4
    logic        cFlush = 1'b0, cInValid = 1'b0, cOutReady = 1'b0;
    logic [15:0] cInData = '0;
    logic        cInReady, cOutValid;
    logic [15:0] cOutData;

`ifdef SRC_PIPE_OCC_EN
    logic [1:0] aOcc;
    logic [1:0] bOcc;
    logic [2:0] cOcc;
`endif

    always #5 clk = ~clk;

    src_pipe #(.WIDTH(8), .DEPTH(2)) dutA (
        .clk(clk), .rst_n(rst_n), .flush(aFlush), .in_valid(aInValid), .in_data(aInData),
        .in_ready(aInReady), .out_valid(aOutValid), .out_data(aOutData), .out_ready(aOutReady)
`ifdef SRC_PIPE_OCC_EN
        , .occupancy(aOcc)
`endif
    );

    src_pipe #(.WIDTH(8), .DEPTH(3)) dutB (
        .clk(clk), .rst_n(rst_n), .flush(bFlush), .in_valid(bInValid), .in_data(bInData),
        .in_ready(bInReady), .out_valid(bOutValid), .out_data(bOutData), .out_ready(bOutReady)
`ifdef SRC_PIPE_OCC_EN
        , .occupancy(bOcc)
`endif
    );

    src_pipe #(.WIDTH(16), .DEPTH(4)) dutC (
        .clk(clk), .rst_n(rst_n), .flush(cFlush), .in_valid(cInValid), .in_data(cInData),
        .in_ready(cInReady), .out_valid(cOutValid), .out_data(cOutData), .out_ready(cOutReady)
`ifdef SRC_PIPE_OCC_EN
        , .occupancy(cOcc)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic outReady,
                                 input logic flushIn);
        @(negedge clk);
        aInValid  = valid;
        aInData   = data;
        aOutReady = outReady;
        aFlush    = flushIn;
    endtask

    logic [7:0]  streamVals [3] = '{8'h11, 8'h22, 8'h33};
    logic [15:0] expQ [$];
    logic [15:0] expItem;

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        checkOutput("resetOutValid", 32'(aOutValid), 32'd0);
        checkOutput("resetOutData",  32'(aOutData),  32'd0);
        checkOutput("resetInReady",  32'(aInReady),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postResetInReady", 32'(aInReady), 32'd1);

        // Streaming through DEPTH=3 with out_ready held high
        $display("[TB] streaming test");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                checkOutput($sformatf("streamValid%0d", k), 32'(bOutValid), 32'd1);
                checkOutput($sformatf("streamData%0d", k),  32'(bOutData),  32'(streamVals[k-3]));
            end else begin
                checkOutput($sformatf("streamIdle%0d", k), 32'(bOutValid), 32'd0);
            end
            bInValid = (k < 3);
            bInData  = (k < 3) ? streamVals[k] : 8'h00;
        end
        bInValid = 1'b0;

        // Asynchronous reset with two items in flight
        $display("[TB] mid-stream reset test");
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h5B, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("preResetData", 32'(aOutData), 32'h5A);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetValid",   32'(aOutValid), 32'd0);
        checkOutput("midResetData",    32'(aOutData),  32'd0);
        checkOutput("midResetInReady", 32'(aInReady),  32'd0);
`ifdef SRC_PIPE_OCC_EN
        checkOutput("midResetOcc", 32'(aOcc), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Backpressure on DEPTH=2
        $display("[TB] backpressure test");
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        #1 checkOutput("bpReadyA1", 32'(aInReady), 32'd1);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        #1 checkOutput("bpReadyA2", 32'(aInReady), 32'd1);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        #1 checkOutput("bpStallReady", 32'(aInReady), 32'd0);
        checkOutput("bpStallData", 32'(aOutData), 32'hA1);
`ifdef SRC_PIPE_OCC_EN
        checkOutput("bpFullOcc", 32'(aOcc), 32'd2);
`endif
        applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0);
        #1 checkOutput("bpReleaseReady", 32'(aInReady), 32'd1);
        checkOutput("bpOutA1", 32'(aOutData), 32'hA1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("bpOutA2", 32'(aOutData), 32'hA2);
        checkOutput("bpValidA2", 32'(aOutValid), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("bpOutA3", 32'(aOutData), 32'hA3);
`ifdef SRC_PIPE_OCC_EN
        checkOutput("bpOccA3", 32'(aOcc), 32'd1);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("bpDrained", 32'(aOutValid), 32'd0);

        // Full pipe with simultaneous input and output transfer
        $display("[TB] full simultaneous test");
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB3, 1'b1, 1'b0);
        #1 checkOutput("fullPassReady", 32'(aInReady), 32'd1);
`ifdef SRC_PIPE_OCC_EN
        checkOutput("fullOccBefore", 32'(aOcc), 32'd2);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("fullOutB2", 32'(aOutData), 32'hB2);
        checkOutput("fullValidB2", 32'(aOutValid), 32'd1);
`ifdef SRC_PIPE_OCC_EN
        checkOutput("fullOccAfter", 32'(aOcc), 32'd2);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("fullOutB3", 32'(aOutData), 32'hB3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("fullDrained", 32'(aOutValid), 32'd0);

        // Flush with two items held and a new item offered
        $display("[TB] flush test");
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1);
        #1 checkOutput("flushInReady", 32'(aInReady), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1 checkOutput("flushOutValid", 32'(aOutValid), 32'd0);
        checkOutput("flushOutData", 32'(aOutData), 32'd0);
`ifdef SRC_PIPE_OCC_EN
        checkOutput("flushOcc", 32'(aOcc), 32'd0);
`endif
        applyStimulus(1'b1, 8'hC4, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1 checkOutput("postFlushData", 32'(aOutData), 32'hC4);
        checkOutput("postFlushValid", 32'(aOutValid), 32'd1);

        // Random bubbles and backpressure on DEPTH=4, scoreboarded
        $display("[TB] random scoreboard test");
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            cInValid  = 1'($urandom_range(0, 1));
            cInData   = 16'($urandom_range(0, 65535));
            cOutReady = ($urandom_range(0, 3) != 0);
            #1;
`ifdef SRC_PIPE_OCC_EN
            checkOutput("rndOcc", 32'(cOcc), 32'(expQ.size()));
`endif
            checkOutput("rndInReady", 32'(cInReady), 32'((expQ.size() < 4) || cOutReady));
            if (cOutValid && cOutReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("rndSpurious", 32'(cOutValid), 32'd0);
                end else begin
                    expItem = expQ.pop_front();
                    checkOutput("rndData", 32'(cOutData), 32'(expItem));
                end
            end
            if (cInValid && cInReady) begin
                expQ.push_back(cInData);
            end
        end
        cInValid  = 1'b0;
        cOutReady = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            if (cOutValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("drainSpurious", 32'(cOutValid), 32'd0);
                end else begin
                    expItem = expQ.pop_front();
                    checkOutput("drainData", 32'(cOutData), 32'(expItem));
                end
            end
        end
        checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("drainValid", 32'(cOutValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
